f1_light_seq: RTL and testbench
===============================

# f1_light_seq

Parametrised Formula-1 start-light sequencer with built-in tick prescaler. After a trigger, it lights NUM_LIGHTS lamps one per tick. It holds them for a pseudo-random number of ticks, then extinguishes all lamps together. It supersedes the fixed 8-lamp FSM plus external tick-generator pairing and drives the lamp bar directly from the board top level.

## Interface
Parameters:
- NUM_LIGHTS, 8: lamp count and width of data_out; 1..32.
- WIDTH, 16: width of N and of the prescaler counter.
- LFSR_WIDTH, 7: random-delay LFSR width; 4..8 supported.
- REACT_WIDTH, 16: reaction-timer width; used only with the macro.

Ports:
- clk  in  1: single clock; all state on rising edge.
- rst  in  1: asynchronous, active-low reset.
- N  in  WIDTH: tick divisor; one tick every N+1 enabled cycles.
- en  in  1: global enable; 0 freezes prescaler and FSM.
- trigger  in  1: start request, level-sampled.
- data_out  out  NUM_LIGHTS: lamp bar; bit 0 lights first.
- busy  out  1: high in any non-IDLE state.
- done  out  1: one-cycle pulse on the cycle data_out clears after a full sequence.
- react  in  1: driver button; macro only.
- react_time  out  REACT_WIDTH: cycles from lights-out to react; macro only.
- react_valid  out  1: one-cycle pulse, react_time updated; macro only.
- jump_start  out  1: one-cycle pulse, react during FILL/HOLD; macro only.

## Operation
- States: IDLE, FILL, HOLD, OUT; WAIT_REACT exists only with the macro.
- Prescaler:
  - Down-counter, decrements while en=1 in FILL/HOLD/OUT.
  - Tick is asserted when count==0 and en=1; the counter then reloads to N.
  - N is sampled only at reload, so a change mid-run takes effect at the next reload.
  - N=0 gives a tick every enabled cycle.
- IDLE:
  - trigger=1 and en=1 moves the FSM to FILL, loads the prescaler with N, and sets data_out=0.
  - trigger while busy is ignored.
- FILL: each tick shifts data_out left with a 1 inserted at bit 0. On the tick that makes data_out all-ones, the FSM enters HOLD.
- HOLD entry: delay register loads the current LFSR value (always nonzero, 1..2^LFSR_WIDTH-1).
- HOLD: each tick decrements delay. The tick where delay==1 clears data_out to 0, pulses done and moves to OUT.
- OUT: one-cycle state, then IDLE (or WAIT_REACT with the macro).
- LFSR:
  - Fibonacci, maximal-length taps, steps every clock regardless of en or state.
  - Reset seed is 1.
- en=0: state, data_out, prescaler and delay hold; the LFSR keeps stepping.
- Reset: data_out=0, busy=0, done=0, react_time=0, react_valid=0, jump_start=0; state IDLE; prescaler=0; LFSR=1.
- Reset mid-sequence: all lamps clear immediately (asynchronous).

## Timing
- Trigger accepted at edge E: busy=1 after E. data_out=1 after edge E+N+1, then one more lamp every N+1 cycles.
- data_out reaches all-ones at edge E+NUM_LIGHTS*(N+1).
- Lights-out follows delay*(N+1) cycles later, with done high for exactly that one cycle.
- busy falls at the cycle after OUT (no macro).
- The earliest re-trigger is accepted one cycle after busy falls.

## Configuration
- F1_REACTION_TIMER_EN defined:
  - OUT goes to WAIT_REACT.
  - react_time counts clk cycles from the OUT cycle (0 in OUT), saturating at all-ones.
  - First cycle with react=1: react_time freezes and is held until the next WAIT_REACT, react_valid pulses, FSM returns to IDLE.
  - react=1 in FILL/HOLD: jump_start pulses, data_out clears, FSM returns to IDLE, no done.
  - WAIT_REACT ignores en.
- Undefined: react is ignored, react_time/react_valid/jump_start are tied 0, and WAIT_REACT is absent.

## Structure
- Package f1_pkg holds:
  - the state enum;
  - the LFSR tap constant table indexed by LFSR_WIDTH (4:0x9, 5:0x12, 6:0x21, 7:0x41, 8:0xB8);
  - a lamp-mask helper function.
- Sub-module tick_gen: prescaler with clk, rst, en, load, N in and tick out. It is instantiated once.

## Test plan
- Reset, then NUM_LIGHTS=8, N=3, trigger pulse: data_out steps 0x01,0x03,…,0xFF every 4 cycles; 0xFF exactly 32 cycles after acceptance.
- Hold phase: bench LFSR model gives the delay d. Check data_out returns to 0 exactly 4*d cycles after 0xFF, with done high one cycle and busy low the next.
- en low for 10 cycles mid-FILL: data_out and cycle-to-next-lamp count both freeze. Total sequence is stretched by exactly 10 cycles.
- trigger held high through a whole run: no restart while busy; a new sequence starts the cycle after busy falls.
- rst low mid-HOLD: data_out=0 and busy=0 without a clock edge. After release, the next trigger restarts from 0x01.
- Macro on: react 25 cycles after lights-out gives react_time=25 with a react_valid pulse. react during FILL gives a jump_start pulse, data_out=0 and no done.

Source files
------------

// File: rtl/f1_light_seq_pkg.sv
// ============================================================================
// Module      : f1_pkg
// Description : Shared types and constants for the f1_light_seq start-light
//               sequencer. Optional macro: F1_REACTION_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package f1_pkg;

`ifdef F1_REACTION_TIMER_EN
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_HOLD       = 3'd2,
        ST_OUT        = 3'd3,
        ST_WAIT_REACT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_HOLD = 3'd2,
        ST_OUT  = 3'd3
    } state_t;
`endif

    // Maximal-length Fibonacci taps, indexed by LFSR width.
    localparam logic [7:0] c_lfsr_taps [4:8] = '{8'h09, 8'h12, 8'h21, 8'h41, 8'hB8};

    function automatic logic [31:0] lamp_mask(input int unsigned n);
        if (n >= 32)
            return '1;
        else
            return (32'd1 << n) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/f1_light_seq_tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Reloadable down-counting prescaler; one tick every N+1
//               enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] N,
    output logic             tick
);

    logic [WIDTH-1:0] r_count;

    // N is only sampled here, so a mid-run change lands at the next reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= N;
        end else if (en) begin
            if (r_count == '0)
                r_count <= N;
            else
                r_count <= r_count - WIDTH'(1);
        end
    end

    assign tick = en && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/f1_light_seq.sv
// ============================================================================
// Module      : f1_light_seq
// Description : F1 start-light sequencer: fill lamps one per tick, hold for an
//               LFSR-random tick count, then lights out.
//               Optional macro: F1_REACTION_TIMER_EN (reaction timer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module f1_light_seq
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS  = 8,
    parameter int WIDTH       = 16,
    parameter int LFSR_WIDTH  = 7,
    parameter int REACT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       N,
    input  logic                   en,
    input  logic                   trigger,
    output logic [NUM_LIGHTS-1:0]  data_out,
    output logic                   busy,
    output logic                   done,
    input  logic                   react,
    output logic [REACT_WIDTH-1:0] react_time,
    output logic                   react_valid,
    output logic                   jump_start
);

    localparam logic [31:0]            c_mask32 = lamp_mask(NUM_LIGHTS);
    localparam logic [NUM_LIGHTS-1:0]  c_all_on = c_mask32[NUM_LIGHTS-1:0];
    localparam logic [7:0]             c_taps8  = c_lfsr_taps[LFSR_WIDTH];
    localparam logic [LFSR_WIDTH-1:0]  c_taps   = c_taps8[LFSR_WIDTH-1:0];

    state_t                  r_state, w_state_nxt;
    logic [NUM_LIGHTS-1:0]   r_data_out, w_data_nxt, w_shift;
    logic [LFSR_WIDTH-1:0]   r_delay, w_delay_nxt, r_lfsr;
    logic                    r_done, w_done_nxt;
    logic                    w_tick, w_tick_en, w_load;

`ifdef F1_REACTION_TIMER_EN
    logic [REACT_WIDTH-1:0]  r_react_time, w_rtime_nxt, w_rtime_inc;
    logic                    r_react_valid, w_rvalid_nxt;
    logic                    r_jump_start, w_jump_nxt;

    assign w_rtime_inc = (r_react_time == '1) ? r_react_time : r_react_time + REACT_WIDTH'(1);
`endif

    assign w_tick_en = en && ((r_state == ST_FILL) || (r_state == ST_HOLD) || (r_state == ST_OUT));
    assign w_shift   = (r_data_out << 1) | NUM_LIGHTS'(1);

    tick_gen #(
        .WIDTH (WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_tick_en),
        .load (w_load),
        .N    (N),
        .tick (w_tick)
    );

    // Free-running so the hold length depends on when the trigger arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_lfsr <= LFSR_WIDTH'(1);
        else
            r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], ^(r_lfsr & c_taps)};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data_out;
        w_delay_nxt = r_delay;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
`ifdef F1_REACTION_TIMER_EN
        w_rtime_nxt  = r_react_time;
        w_rvalid_nxt = 1'b0;
        w_jump_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (trigger && en) begin
                    w_state_nxt = ST_FILL;
                    w_data_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            ST_FILL: begin
`ifdef F1_REACTION_TIMER_EN
                if (react) begin
                    w_jump_nxt  = 1'b1;
                    w_data_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else
`endif
                if (w_tick) begin
                    w_data_nxt = w_shift;
                    if (w_shift == c_all_on) begin
                        w_state_nxt = ST_HOLD;
                        w_delay_nxt = r_lfsr;
                    end
                end
            end
            ST_HOLD: begin
`ifdef F1_REACTION_TIMER_EN
                if (react) begin
                    w_jump_nxt  = 1'b1;
                    w_data_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else
`endif
                if (w_tick) begin
                    if (r_delay == LFSR_WIDTH'(1)) begin
                        w_data_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_OUT;
`ifdef F1_REACTION_TIMER_EN
                        w_rtime_nxt = '0;
`endif
                    end else begin
                        w_delay_nxt = r_delay - LFSR_WIDTH'(1);
                    end
                end
            end
            ST_OUT: begin
`ifdef F1_REACTION_TIMER_EN
                w_rtime_nxt = w_rtime_inc;
                if (en)
                    w_state_nxt = ST_WAIT_REACT;
`else
                if (en)
                    w_state_nxt = ST_IDLE;
`endif
            end
`ifdef F1_REACTION_TIMER_EN
            ST_WAIT_REACT: begin
                if (react) begin
                    w_rvalid_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_rtime_nxt = w_rtime_inc;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_data_out <= '0;
            r_delay    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_out <= w_data_nxt;
            r_delay    <= w_delay_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign data_out = r_data_out;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

`ifdef F1_REACTION_TIMER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
            r_jump_start  <= 1'b0;
        end else begin
            r_react_time  <= w_rtime_nxt;
            r_react_valid <= w_rvalid_nxt;
            r_jump_start  <= w_jump_nxt;
        end
    end

    assign react_time  = r_react_time;
    assign react_valid = r_react_valid;
    assign jump_start  = r_jump_start;
`else
    logic w_unused_react;
    assign w_unused_react = react;
    assign react_time     = '0;
    assign react_valid    = 1'b0;
    assign jump_start     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_f1_light_seq.sv
// ============================================================================
// Module      : tb_f1_light_seq
// Description : Directed self-checking bench for f1_light_seq (8 lamps,
//               7-bit LFSR). Optional macro: F1_REACTION_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f1_light_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] N;
    logic        en;
    logic        trigger;
    logic        react;
    logic [7:0]  data_out;
    logic        busy;
    logic        done;
    logic [15:0] react_time;
    logic        react_valid;
    logic        jump_start;

    int errors = 0;
    int checks = 0;

    logic [6:0] m_lfsr;
    logic [6:0] m_prev;

    f1_light_seq #(
        .NUM_LIGHTS  (8),
        .WIDTH       (16),
        .LFSR_WIDTH  (7),
        .REACT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .N           (N),
        .en          (en),
        .trigger     (trigger),
        .data_out    (data_out),
        .busy        (busy),
        .done        (done),
        .react       (react),
        .react_time  (react_time),
        .react_valid (react_valid),
        .jump_start  (jump_start)
    );

    always #5 clk = ~clk;

    // Reference LFSR x^7+x^6+1, seed 1; m_prev is the value before the last edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 7'd1;
            m_prev <= 7'd1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[0]};
        end
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts just after the accepting edge; ends just after the all-ones edge.
    task automatic fill_check(input string tag, input int p);
        logic [7:0] prev;
        logic [7:0] lamp;
        prev = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            lamp = {prev[6:0], 1'b1};
            if (p > 1) begin
                step(p - 1);
                chk({tag, " pre-lamp"}, 32'(data_out), 32'(prev));
            end
            step(1);
            chk({tag, " lamp"}, 32'(data_out), 32'(lamp));
            prev = lamp;
        end
        chk({tag, " busy in fill"}, 32'(busy), 32'd1);
    endtask

    // Starts just after the all-ones edge; ends just after lights-out.
    task automatic hold_phase(input string tag, input int p);
        int d;
        d = int'(m_prev);
        chk({tag, " delay nonzero"}, 32'(d != 0), 32'd1);
        step(p * d - 1);
        chk({tag, " still lit"}, 32'(data_out), 32'hFF);
        chk({tag, " no early done"}, 32'(done), 32'd0);
        step(1);
        chk({tag, " lights out"}, 32'(data_out), 32'h00);
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " busy in out"}, 32'(busy), 32'd1);
    endtask

    task automatic back_to_idle(input string tag);
        step(1);
`ifdef F1_REACTION_TIMER_EN
        chk({tag, " busy wait react"}, 32'(busy), 32'd1);
        react = 1'b1;
        step(1);
        react = 1'b0;
        chk({tag, " react valid"}, 32'(react_valid), 32'd1);
`endif
        chk({tag, " busy low"}, 32'(busy), 32'd0);
        chk({tag, " done cleared"}, 32'(done), 32'd0);
    endtask

    initial begin
        N       = 16'd3;
        en      = 1'b0;
        trigger = 1'b0;
        react   = 1'b0;

        #2 rst = 1'b0;
        #1;
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset react_time", 32'(react_time), 32'd0);
        chk("reset react_valid", 32'(react_valid), 32'd0);
        chk("reset jump_start", 32'(jump_start), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        step(1);

        // Run 1: basic sequence with N=3
        en = 1'b1;
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        chk("run1 busy after accept", 32'(busy), 32'd1);
        chk("run1 data after accept", 32'(data_out), 32'h00);
        fill_check("run1", 4);
        hold_phase("run1", 4);
        back_to_idle("run1");

        // Run 2: enable dropped for 10 cycles mid-fill
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(4);
        chk("run2 first lamp", 32'(data_out), 32'h01);
        step(2);
        en = 1'b0;
        step(10);
        chk("run2 frozen data", 32'(data_out), 32'h01);
        chk("run2 frozen busy", 32'(busy), 32'd1);
        en = 1'b1;
        step(1);
        chk("run2 resume count", 32'(data_out), 32'h01);
        step(1);
        chk("run2 second lamp", 32'(data_out), 32'h03);
        for (int k = 3; k <= 8; k++) begin
            step(3);
            chk("run2 pre-lamp", 32'(data_out), 32'((1 << (k - 1)) - 1));
            step(1);
            chk("run2 lamp", 32'(data_out), 32'((1 << k) - 1));
        end
        hold_phase("run2", 4);
        back_to_idle("run2");

        // Run 3: trigger held high for the whole run, then retriggers
        trigger = 1'b1;
        step(1);
        chk("run3 accept", 32'(busy), 32'd1);
        fill_check("run3", 4);
        hold_phase("run3", 4);
        back_to_idle("run3");
        step(1);
        chk("run3 retrigger busy", 32'(busy), 32'd1);
        chk("run3 retrigger data", 32'(data_out), 32'h00);
        trigger = 1'b0;

        // Run 4: asynchronous reset mid-hold
        fill_check("run4", 4);
        step(2);
        #2 rst = 1'b0;
        #1;
        chk("async rst data", 32'(data_out), 32'h00);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        step(1);
        chk("post rst idle", 32'(busy), 32'd0);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        fill_check("run5", 4);
        hold_phase("run5", 4);
        back_to_idle("run5");

        // Run 6: N=0, a tick every enabled cycle
        N = 16'd0;
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        fill_check("n0", 1);
        hold_phase("n0", 1);
        back_to_idle("n0");
        N = 16'd3;

`ifdef F1_REACTION_TIMER_EN
        // Jump start during fill
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(4);
        chk("js first lamp", 32'(data_out), 32'h01);
        react = 1'b1;
        step(1);
        react = 1'b0;
        chk("js pulse", 32'(jump_start), 32'd1);
        chk("js data cleared", 32'(data_out), 32'h00);
        chk("js no done", 32'(done), 32'd0);
        chk("js idle", 32'(busy), 32'd0);
        step(1);
        chk("js pulse end", 32'(jump_start), 32'd0);

        // Reaction 25 cycles after lights-out
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        fill_check("rt", 4);
        hold_phase("rt", 4);
        step(25);
        chk("rt counting", 32'(react_time), 32'd25);
        react = 1'b1;
        step(1);
        react = 1'b0;
        chk("rt valid", 32'(react_valid), 32'd1);
        chk("rt time", 32'(react_time), 32'd25);
        chk("rt idle", 32'(busy), 32'd0);
        step(1);
        chk("rt valid end", 32'(react_valid), 32'd0);
        chk("rt time held", 32'(react_time), 32'd25);
`else
        // react has no effect without the reaction timer
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(4);
        chk("nr first lamp", 32'(data_out), 32'h01);
        react = 1'b1;
        step(1);
        react = 1'b0;
        chk("nr no jump", 32'(jump_start), 32'd0);
        chk("nr no valid", 32'(react_valid), 32'd0);
        chk("nr time zero", 32'(react_time), 32'd0);
        chk("nr still busy", 32'(busy), 32'd1);
        chk("nr data kept", 32'(data_out), 32'h01);
        step(3);
        chk("nr next lamp", 32'(data_out), 32'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
